// File: rtl/mux_pkg.sv
// Shared constants for the arbitrated 2:1 mux: source encodings and default bus width.
package mux_pkg;

  localparam int   BUS_WIDTH = 4;
  localparam logic SRC_A     = 1'b0;
  localparam logic SRC_B     = 1'b1;

  function automatic logic other_src(input logic src);
    return ~src;
  endfunction

endpackage

// File: rtl/mux.sv
// Plain 2:1 datapath mux; switch selects b when high (SRC_B), a otherwise.
module mux #(
  parameter int WIDTH = mux_pkg::BUS_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             switch,
  output logic [WIDTH-1:0] q
);
  import mux_pkg::*;

  assign q = (switch == SRC_B) ? b : a;

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin priority: picks the valid source, alternating on contention,
// with an optional burst lock that lets the last winner keep the grant.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last,
  input  logic [1:0] lock,
  output logic       sel
);
  import mux_pkg::*;

  // With no requester the choice is irrelevant; ready is gated by load upstream.
  always_comb begin
    sel = other_src(last);
    if (lock[last] && valid[last]) begin
      sel = last;
    end else if (valid == 2'b01) begin
      sel = SRC_A;
    end else if (valid == 2'b10) begin
      sel = SRC_B;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter feeding a single-entry registered output stage.
// Define MUX_ARB_LOCK_EN to add a_lock/b_lock burst-hold inputs.
//
// Handshakes: a word moves on a channel in any cycle where valid and ready are
// both high at the rising edge; valid must not depend on ready, ready may
// depend on valid, and once a_ready/b_ready is seen the word is taken.
module mux_arbiter #(
  parameter int BUS_WIDTH = mux_pkg::BUS_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] a,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic                 b_valid,
  output logic                 b_ready,
  output logic [BUS_WIDTH-1:0] q,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic                 q_src
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic                 a_lock,
  input  logic                 b_lock
`endif
);
  import mux_pkg::*;

  logic                 last;
  logic                 sel;
  logic                 space;
  logic                 load;
  logic [1:0]           lock;
  logic [BUS_WIDTH-1:0] mux_q;

`ifdef MUX_ARB_LOCK_EN
  assign lock = {b_lock, a_lock};
`else
  assign lock = 2'b00;
`endif

  rr_arb2 u_arb (
    .valid ({b_valid, a_valid}),
    .last  (last),
    .lock  (lock),
    .sel   (sel)
  );

  mux #(.WIDTH(BUS_WIDTH)) u_mux (
    .a      (a),
    .b      (b),
    .switch (sel),
    .q      (mux_q)
  );

  // A simultaneous drain and load keeps the stage full at one word per cycle.
  assign space   = !q_valid || q_ready;
  assign load    = rst_n && space && (a_valid || b_valid);
  assign a_ready = load && (sel == SRC_A);
  assign b_ready = load && (sel == SRC_B);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q       <= '0;
      q_valid <= 1'b0;
      q_src   <= SRC_A;
      last    <= SRC_B;
    end else if (load) begin
      q       <= mux_q;
      q_valid <= 1'b1;
      q_src   <= sel;
      last    <= sel;
    end else if (q_valid && q_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Table-driven bench for mux_arbiter with a scoreboard of accepted words.
// Lock vectors are included when MUX_ARB_LOCK_EN is defined.
module tb_mux_arbiter;
  import mux_pkg::*;

  typedef struct {
    logic                 rst_n;
    logic                 av;
    logic [BUS_WIDTH-1:0] a;
    logic                 bv;
    logic [BUS_WIDTH-1:0] b;
    logic                 qr;
    logic                 al;
    logic                 bl;
    logic                 ear;
    logic                 ebr;
    logic                 eqv;
    logic [BUS_WIDTH-1:0] eq;
    logic                 esrc;
  } vec_t;

  logic                 clk;
  logic                 rst_n;
  logic [BUS_WIDTH-1:0] a;
  logic                 a_valid;
  logic                 a_ready;
  logic [BUS_WIDTH-1:0] b;
  logic                 b_valid;
  logic                 b_ready;
  logic [BUS_WIDTH-1:0] q;
  logic                 q_valid;
  logic                 q_ready;
  logic                 q_src;
  logic                 a_lock;
  logic                 b_lock;

  vec_t                 vecs[$];
  logic [BUS_WIDTH:0]   exp_q[$];
  int                   checks;
  int                   errors;
  int                   cur_row;

  mux_arbiter #(.BUS_WIDTH(BUS_WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .b       (b),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .q_src   (q_src)
`ifdef MUX_ARB_LOCK_EN
    ,
    .a_lock  (a_lock),
    .b_lock  (b_lock)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic av, input logic [3:0] da,
                              input logic bv, input logic [3:0] db, input logic qr,
                              input logic al, input logic bl, input logic ear,
                              input logic ebr, input logic eqv, input logic [3:0] eq,
                              input logic esrc);
    vec_t v;
    v.rst_n = r;   v.av = av;   v.a = da;    v.bv = bv;  v.b = db;  v.qr = qr;
    v.al = al;     v.bl = bl;   v.ear = ear; v.ebr = ebr;
    v.eqv = eqv;   v.eq = eq;   v.esrc = esrc;
    vecs.push_back(v);
  endfunction

  // driver: one table row per clock cycle, checked just after inputs settle
  task automatic apply(input vec_t v);
    logic [BUS_WIDTH:0] got;
    logic [BUS_WIDTH:0] want;
    @(negedge clk);
    rst_n = v.rst_n; a = v.a; a_valid = v.av; b = v.b; b_valid = v.bv;
    q_ready = v.qr; a_lock = v.al; b_lock = v.bl;
    #1;
    check("a_ready", a_ready, v.ear);
    check("b_ready", b_ready, v.ebr);
    check("q_valid", q_valid, v.eqv);
    check("q",       q,       v.eq);
    check("q_src",   q_src,   v.esrc);
    if (!v.rst_n) begin
      exp_q.delete();
    end else begin
      if (q_valid && q_ready) begin
        got = {q_src, q};
        if (exp_q.size() == 0) begin
          check("sb_underflow", 8'd1, 8'd0);
        end else begin
          want = exp_q.pop_front();
          check("sb_word", 8'(got), 8'(want));
        end
      end
      if (v.ear) exp_q.push_back({SRC_A, v.a});
      if (v.ebr) exp_q.push_back({SRC_B, v.b});
    end
  endtask

  initial begin
    checks = 0; errors = 0; cur_row = 0;
    rst_n = 1'b0; a = '0; a_valid = 1'b0; b = '0; b_valid = 1'b0;
    q_ready = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
    repeat (2) @(negedge clk);

    // reset held with both sources offering
    repeat (3) add(0, 1, 4'h3, 1, 4'h5, 1, 0, 0, 0, 0, 0, 4'h0, 0);
    // single source A
    add(1, 1, 4'h1, 0, 4'h0, 1, 0, 0, 1, 0, 0, 4'h0, 0);
    repeat (3) add(1, 1, 4'h1, 0, 4'h0, 1, 0, 0, 1, 0, 1, 4'h1, 0);
    // reset restores last=B so contention opens with A
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 4'h1, 0);
    // contention: strict alternation
    add(1, 1, 4'h3, 1, 4'h5, 1, 0, 0, 1, 0, 0, 4'h0, 0);
    add(1, 1, 4'h3, 1, 4'h5, 1, 0, 0, 0, 1, 1, 4'h3, 0);
    add(1, 1, 4'h3, 1, 4'h5, 1, 0, 0, 1, 0, 1, 4'h5, 1);
    add(1, 1, 4'h3, 1, 4'h5, 1, 0, 0, 0, 1, 1, 4'h3, 0);
    add(1, 1, 4'h3, 1, 4'h5, 1, 0, 0, 1, 0, 1, 4'h5, 1);
    add(1, 1, 4'h3, 1, 4'h5, 1, 0, 0, 0, 1, 1, 4'h3, 0);
    // backpressure: 7 held while B waits, B taken when q_ready returns
    add(1, 1, 4'h7, 0, 4'h0, 1, 0, 0, 1, 0, 1, 4'h5, 1);
    repeat (3) add(1, 0, 4'h0, 1, 4'h9, 0, 0, 0, 0, 0, 1, 4'h7, 0);
    add(1, 0, 4'h0, 1, 4'h9, 1, 0, 0, 0, 1, 1, 4'h7, 0);
    add(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 1, 4'h9, 1);
    // reset during a stall drops the held word
    add(1, 1, 4'hA, 0, 4'h0, 0, 0, 0, 1, 0, 0, 4'h9, 1);
    add(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 4'hA, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 4'hA, 0);
    add(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h0, 0);
    // loser drops valid; next contest goes to the other side
    add(1, 1, 4'h2, 1, 4'h4, 1, 0, 0, 1, 0, 0, 4'h0, 0);
    add(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 1, 4'h2, 0);
    add(1, 1, 4'h6, 1, 4'h8, 1, 0, 0, 0, 1, 0, 4'h2, 0);
    add(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 1, 4'h8, 1);
    add(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h8, 1);
`ifdef MUX_ARB_LOCK_EN
    // burst lock on A, then release hands the grant to B
    add(1, 1, 4'h1, 1, 4'h2, 1, 1, 0, 1, 0, 0, 4'h8, 1);
    repeat (3) add(1, 1, 4'h1, 1, 4'h2, 1, 1, 0, 1, 0, 1, 4'h1, 0);
    add(1, 1, 4'h1, 1, 4'h2, 1, 0, 0, 0, 1, 1, 4'h1, 0);
    add(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 1, 4'h2, 1);
    add(1, 0, 4'h0, 0, 4'h0, 1, 0, 0, 0, 0, 0, 4'h2, 1);
`endif

    foreach (vecs[i]) begin
      cur_row = i;
      apply(vecs[i]);
    end

    // every accepted word must have been delivered
    cur_row = vecs.size();
    check("sb_empty", 8'(exp_q.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
